// File: rtl/icache_responder_pkg.sv
// Shared types for the direct-mapped instruction cache: controller state,
// the fetch address split, and the layout of one cache frame.
package icache_responder_pkg;

    localparam int ICACHE_FRAMES = 16;
    localparam int ICACHE_IDX_W  = $clog2(ICACHE_FRAMES);
    localparam int ICACHE_TAG_W  = 30 - ICACHE_IDX_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icache_addr_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        logic [31:0]             data;
    } icache_frame_t;

endpackage

// File: rtl/icache_responder_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// slave is the cache's view; master is the view of whatever drives it
// (fetch stage plus memory controller, or a testbench).
interface icache_responder_if;

    logic        dp_iREN;
    logic [31:0] dp_iaddr;
    logic        dp_ihit;
    logic [31:0] dp_iload;
    logic        mem_iREN;
    logic [31:0] mem_iaddr;
    logic        mem_iwait;
    logic [31:0] mem_iload;

    modport slave (
        input  dp_iREN, dp_iaddr, mem_iwait, mem_iload,
        output dp_ihit, dp_iload, mem_iREN, mem_iaddr
    );

    modport master (
        output dp_iREN, dp_iaddr, mem_iwait, mem_iload,
        input  dp_ihit, dp_iload, mem_iREN, mem_iaddr
    );

endinterface

// File: rtl/icache_responder_frame_array.sv
// Storage for the one-word cache frames: valid bits with asynchronous and
// bulk clear, tag and data words, one combinational read port and one
// write port. A bulk clear in the same cycle as a write drops the write.
module icache_frame_array #(
    parameter int NFRAMES = 16,
    parameter int IDX_W   = $clog2(NFRAMES),
    parameter int TAG_W   = 30 - IDX_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data
);

    logic [NFRAMES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q  [NFRAMES];
    logic [31:0]        data_q [NFRAMES];

    // Valid bits: reset and flush wipe every frame, a fill marks one frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
        end else if (clear) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset; they mean nothing until the valid bit is set.
    always_ff @(posedge CLK) begin
        if (wr_en && !clear) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache. Hits answer in the request cycle; a miss
// latches the word address and fetches it with one memory read, then the
// request is re-evaluated against the freshly written frame.
module icache_responder
    import icache_responder_pkg::*;
#(
    parameter  int NFRAMES = ICACHE_FRAMES,
    localparam int IDX_W   = $clog2(NFRAMES),
    localparam int TAG_W   = 30 - IDX_W
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                flush,
    icache_responder_if.slave   bus,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt
);

    icache_state_t state, next_state;

    logic [29:0]      miss_word;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] fill_tag;
    logic [IDX_W-1:0] fill_idx;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;

    logic             hit;
    logic             miss;
    logic             fill_we;
    logic             dp_ihit;
    logic [31:0]      dp_iload;
    logic             mem_iREN;
    logic [31:0]      mem_iaddr;
    logic             unused_bytoff;

    assign req_tag       = bus.dp_iaddr[31:IDX_W+2];
    assign req_idx       = bus.dp_iaddr[IDX_W+1:2];
    assign fill_tag      = miss_word[29:IDX_W];
    assign fill_idx      = miss_word[IDX_W-1:0];
    assign unused_bytoff = ^bus.dp_iaddr[1:0];

    icache_frame_array #(
        .NFRAMES (NFRAMES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_frames (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (flush),
        .wr_en    (fill_we),
        .wr_idx   (fill_idx),
        .wr_tag   (fill_tag),
        .wr_data  (bus.mem_iload),
        .rd_idx   (req_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data)
    );

    // State register; reset abandons any fill in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: a miss starts a fill; flush or returned data ends it.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (miss) next_state = FILL;
            FILL: if (flush || !bus.mem_iwait) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs: hit lookup only in IDLE, memory request only in FILL.
    always_comb begin
        hit       = 1'b0;
        miss      = 1'b0;
        fill_we   = 1'b0;
        dp_ihit   = 1'b0;
        dp_iload  = '0;
        mem_iREN  = 1'b0;
        mem_iaddr = '0;
        case (state)
            IDLE: begin
                hit      = bus.dp_iREN && rd_valid && (rd_tag == req_tag) && !flush;
                miss     = bus.dp_iREN && !hit && !flush;
                dp_ihit  = hit;
                dp_iload = hit ? rd_data : '0;
            end
            FILL: begin
                mem_iREN  = 1'b1;
                mem_iaddr = {miss_word, 2'b00};
                fill_we   = !bus.mem_iwait && !flush;
            end
            default: ;
        endcase
    end

    // Miss address capture and the free-running hit/miss counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            miss_word <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            if (miss) begin
                miss_word <= bus.dp_iaddr[31:2];
                miss_cnt  <= miss_cnt + 32'd1;
            end
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
        end
    end

    assign bus.dp_ihit   = dp_ihit;
    assign bus.dp_iload  = dp_iload;
    assign bus.mem_iREN  = mem_iREN;
    assign bus.mem_iaddr = mem_iaddr;

endmodule
